// File: rtl/conv_pkg.sv
// Shared definitions for the convolution accelerator datapath: width helpers,
// window phase encoding and handshake level constants.
package conv_pkg;

    localparam logic HS_ASSERT   = 1'b1;
    localparam logic HS_DEASSERT = 1'b0;

    // Products from the upstream multiplier appear this many cycles after its operands.
    localparam int MULT_LATENCY = 2;

    typedef enum logic [1:0] {
        PH_FIRST,
        PH_ACCUM,
        PH_LAST
    } win_phase_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int data_width, input int kernel_size);
        return 2 * data_width + clog2(kernel_size);
    endfunction

endpackage

// File: rtl/conv_window_accumulator_if.sv
// Product-in / window-sum-out handshake bundle of the window accumulator.
interface conv_window_accumulator_if
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 9,
    parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, KERNEL_SIZE)
);
    logic [2*DATA_WIDTH-1:0]        prod_data;
    logic                           prod_valid;
    logic                           prod_ready;
    logic                           clear;
    logic [ACC_WIDTH-1:0]           acc_data;
    logic                           acc_valid;
    logic                           acc_ready;
    logic [clog2(KERNEL_SIZE)-1:0]  win_idx;

    modport master (
        output prod_data, prod_valid, clear, acc_ready,
        input  prod_ready, acc_data, acc_valid, win_idx
    );

    modport slave (
        input  prod_data, prod_valid, clear, acc_ready,
        output prod_ready, acc_data, acc_valid, win_idx
    );
endinterface

// File: rtl/conv_acc_out_slot.sv
// Single-entry output holding register for a reduction result; a new load may
// land in the same cycle the previous entry is consumed.
module conv_acc_out_slot
    import conv_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             consume,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= HS_DEASSERT;
            data  <= '0;
        end else if (load) begin
            valid <= HS_ASSERT;
            data  <= load_data;
        end else if (valid && consume) begin
            valid <= HS_DEASSERT;
        end
    end

endmodule

// File: rtl/conv_window_accumulator.sv
// Sums KERNEL_SIZE consecutive unsigned products into one window result and
// hands it to the writeback stage through a single-entry output slot.
module conv_window_accumulator
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 9,
    parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, KERNEL_SIZE)
) (
    input logic clk,
    input logic rst,
    conv_window_accumulator_if.slave bus
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int IDX_W  = clog2(KERNEL_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_SIZE - 1);

    logic [IDX_W-1:0]     win_idx;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] addend;
    logic [ACC_WIDTH-1:0] sum;
    logic                 prod_ready;
    logic                 accept;
    logic                 complete;
    logic                 acc_valid;
    logic [ACC_WIDTH-1:0] acc_data;
    win_phase_e           phase;

    function automatic logic [ACC_WIDTH-1:0] zext(input logic [PROD_W-1:0] p);
        return ACC_WIDTH'(p);
    endfunction

    always_comb begin
        phase = PH_ACCUM;
        if (win_idx == '0)
            phase = PH_FIRST;
        else if (win_idx == LAST_IDX)
            phase = PH_LAST;
    end

    // Only the completing beat needs the output slot free (or draining this cycle).
    assign prod_ready = !bus.clear && ((win_idx != LAST_IDX) || !acc_valid || bus.acc_ready);
    assign accept     = bus.prod_valid && prod_ready;
    assign complete   = accept && (phase == PH_LAST);
    assign addend     = zext(bus.prod_data);
    assign sum        = acc + addend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            win_idx <= '0;
        end else if (bus.clear) begin
            acc     <= '0;
            win_idx <= '0;
        end else if (accept) begin
            unique case (phase)
                PH_FIRST: begin
                    acc     <= addend;
                    win_idx <= IDX_W'(1);
                end
                PH_ACCUM: begin
                    acc     <= sum;
                    win_idx <= win_idx + IDX_W'(1);
                end
                PH_LAST: begin
                    acc     <= '0;
                    win_idx <= '0;
                end
                default: begin
                    acc     <= '0;
                    win_idx <= '0;
                end
            endcase
        end
    end

    conv_acc_out_slot #(
        .WIDTH(ACC_WIDTH)
    ) u_out_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .load_data (sum),
        .consume   (bus.acc_ready),
        .valid     (acc_valid),
        .data      (acc_data)
    );

    assign bus.prod_ready = prod_ready;
    assign bus.acc_valid  = acc_valid;
    assign bus.acc_data   = acc_data;
    assign bus.win_idx    = win_idx;

endmodule

// File: tb/tb_conv_window_accumulator.sv
// Directed bench for conv_window_accumulator at DATA_WIDTH=8, KERNEL_SIZE=9.
module tb_conv_window_accumulator;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    conv_window_accumulator_if #(.DATA_WIDTH(8), .KERNEL_SIZE(9), .ACC_WIDTH(20)) bus ();

    conv_window_accumulator #(
        .DATA_WIDTH(8),
        .KERNEL_SIZE(9),
        .ACC_WIDTH(20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        logic        pv;
        logic        clr;
        logic        ardy;
        logic        rdy;
        logic        vld;
        logic [19:0] data;
        logic [3:0]  idx;
    } vec_t;

    vec_t tbl [29];

    function automatic vec_t mkv(input int prod, input bit pv, input bit clr, input bit ardy,
                                 input bit rdy, input bit vld, input int data, input int idx);
        vec_t v;
        v.prod = 16'(prod);
        v.pv   = pv;
        v.clr  = clr;
        v.ardy = ardy;
        v.rdy  = rdy;
        v.vld  = vld;
        v.data = 20'(data);
        v.idx  = 4'(idx);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle: prod_ready checked before the edge, registered outputs after it.
    task automatic apply(input vec_t v, input string tag);
        bus.prod_data  = v.prod;
        bus.prod_valid = v.pv;
        bus.clear      = v.clr;
        bus.acc_ready  = v.ardy;
        #1;
        check({tag, " prod_ready"}, 32'(bus.prod_ready), 32'(v.rdy));
        @(posedge clk);
        #1;
        check({tag, " acc_valid"}, 32'(bus.acc_valid), 32'(v.vld));
        check({tag, " acc_data"}, 32'(bus.acc_data), 32'(v.data));
        check({tag, " win_idx"}, 32'(bus.win_idx), 32'(v.idx));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // 1..9, then nine 2s back-to-back, idle, nine 0xFFFF, idle; acc_ready held high
        for (int i = 0; i < 9; i++)
            tbl[i] = mkv(i + 1, 1, 0, 1, 1, i == 8, (i == 8) ? 45 : 0, (i + 1) % 9);
        for (int i = 9; i < 18; i++)
            tbl[i] = mkv(2, 1, 0, 1, 1, i == 17, (i == 17) ? 18 : 45, (i - 8) % 9);
        tbl[18] = mkv(0, 0, 0, 1, 1, 0, 18, 0);
        for (int i = 19; i < 28; i++)
            tbl[i] = mkv('hFFFF, 1, 0, 1, 1, i == 27, (i == 27) ? 'h8FFF7 : 18, (i - 18) % 9);
        tbl[28] = mkv(0, 0, 0, 1, 1, 0, 'h8FFF7, 0);

        rst            = 1'b1;
        bus.prod_data  = '0;
        bus.prod_valid = 1'b0;
        bus.clear      = 1'b0;
        bus.acc_ready  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset acc_valid", 32'(bus.acc_valid), 32'd0);
        check("reset acc_data", 32'(bus.acc_data), 32'd0);
        check("reset win_idx", 32'(bus.win_idx), 32'd0);
        rst = 1'b0;
        #1;
        check("post-reset prod_ready", 32'(bus.prod_ready), 32'd1);

        for (int i = 0; i < 29; i++)
            apply(tbl[i], $sformatf("tbl[%0d]", i));

        // Output stalled: window 2 may only stall on its completing beat
        for (int k = 1; k <= 9; k++)
            apply(mkv(k, 1, 0, 0, 1, k == 9, (k == 9) ? 45 : 'h8FFF7, k % 9), $sformatf("stall w1 k%0d", k));
        for (int k = 1; k <= 8; k++)
            apply(mkv(2, 1, 0, 0, 1, 1, 45, k), $sformatf("stall w2 k%0d", k));
        apply(mkv(2, 1, 0, 0, 0, 1, 45, 8), "stall hold");
        apply(mkv(2, 1, 0, 1, 1, 1, 18, 0), "stall release");
        apply(mkv(0, 0, 0, 1, 1, 0, 18, 0), "stall drain");

        // clear mid-window while a sum is pending
        for (int k = 1; k <= 9; k++)
            apply(mkv(k, 1, 0, 0, 1, k == 9, (k == 9) ? 45 : 18, k % 9), $sformatf("clr w1 k%0d", k));
        for (int k = 1; k <= 4; k++)
            apply(mkv(k, 1, 0, 0, 1, 1, 45, k), $sformatf("clr part k%0d", k));
        apply(mkv(5, 1, 1, 0, 0, 1, 45, 0), "clr pulse");
        apply(mkv(0, 0, 0, 1, 1, 0, 45, 0), "clr deliver");
        for (int k = 1; k <= 9; k++)
            apply(mkv(1, 1, 0, 1, 1, k == 9, (k == 9) ? 9 : 45, k % 9), $sformatf("clr w2 k%0d", k));
        apply(mkv(0, 0, 0, 1, 1, 0, 9, 0), "clr idle");

        // Asynchronous reset mid-window with a pending sum
        for (int k = 1; k <= 9; k++)
            apply(mkv(k, 1, 0, 0, 1, k == 9, (k == 9) ? 45 : 9, k % 9), $sformatf("rst w1 k%0d", k));
        for (int k = 1; k <= 3; k++)
            apply(mkv(7, 1, 0, 0, 1, 1, 45, k), $sformatf("rst part k%0d", k));
        bus.prod_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async rst acc_valid", 32'(bus.acc_valid), 32'd0);
        check("async rst acc_data", 32'(bus.acc_data), 32'd0);
        check("async rst win_idx", 32'(bus.win_idx), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int k = 1; k <= 9; k++)
            apply(mkv(k, 1, 0, 1, 1, k == 9, (k == 9) ? 45 : 0, k % 9), $sformatf("rst w2 k%0d", k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
